sdram_wb_arbiter: RTL and testbench
===================================

// Module: sdram_wb_arbiter
// PURPOSE
//  Two-master, one-slave Wishbone arbiter in front of the user-project SDRAM controller.
//  Shares the single SDRAM port between the CPU (master 0) and the matrix DMA (master 1, the dma_* bus).
//  Holds the grant for one complete single-beat transfer and routes ack/read data back only to the granted master.
//  Provides a bounded-latency timeout so a stuck slave cannot hang either master.
// PARAMETERS
//  DMA_PRIO      0    0 = round-robin between masters; 1 = fixed priority, DMA wins ties
//  TIMEOUT_CYC   255  cycles in a GRANT state without sdr_ack_i before a forced timeout completion
//  TO_WIDTH      8    width of the timeout counter; must satisfy 2**TO_WIDTH > TIMEOUT_CYC
// PORTS
//  wb_clk_i       in   1   single clock
//  wb_rst_ni      in   1   synchronous reset, active-low
//  cpu_stb_i/cpu_cyc_i/cpu_we_i  in 1  CPU Wishbone request
//  cpu_sel_i      in   4   CPU byte selects
//  cpu_adr_i      in   32  CPU address
//  cpu_dat_i      in   32  CPU write data
//  cpu_ack_o      out  1   ack to CPU
//  cpu_dat_o      out  32  read data to CPU
//  dma_stb_i/dma_cyc_i/dma_we_i  in 1  DMA Wishbone request
//  dma_sel_i      in   4   DMA byte selects
//  dma_adr_i      in   32  DMA address
//  dma_dat_i      in   32  DMA write data
//  dma_ack_o      out  1   ack to DMA
//  dma_dat_o      out  32  read data to DMA
//  sdr_stb_o/sdr_cyc_o/sdr_we_o  out 1  request to SDRAM controller
//  sdr_sel_o      out  4   byte selects to SDRAM controller
//  sdr_adr_o      out  32  address to SDRAM controller
//  sdr_dat_o      out  32  write data to SDRAM controller
//  sdr_ack_i      in   1   SDRAM ack
//  sdr_dat_i      in   32  SDRAM read data
//  arb_busy_o     out  1   high in any GRANT state
//  arb_timeout_o  out  1   sticky timeout flag; cleared only by reset
// BEHAVIOUR
//  - Request: req_cpu = cpu_cyc_i & cpu_stb_i; req_dma = dma_cyc_i & dma_stb_i.
//  - FSM states: IDLE, GNT_CPU, GNT_DMA. The state register is the grant.
//    - IDLE -> GNT_x when req_x is high.
//    - GNT_x -> IDLE on sdr_ack_i, on timeout, or on abort (req_x low).
//  - Arbitration in IDLE, when both masters request:
//    - DMA_PRIO=1: DMA wins.
//    - DMA_PRIO=0: the master NOT recorded in last_gnt wins.
//    - last_gnt (1 bit) updates on every IDLE->GNT transition. Reset value selects the CPU, so the DMA wins the first tie.
//  - Latency: request sampled in IDLE at cycle N -> sdr_stb_o high at N+1.
//    - A 0-wait slave acks at N+1; the master sees ack at N+1.
//    - FSM is in IDLE at N+2, so a master can re-request every 2 cycles minimum.
//  - Slave-side outputs are combinational muxes of the granted master's inputs.
//    - sdr_stb_o/sdr_cyc_o are qualified by the granted master's req, so an abort drops them the same cycle.
//    - In IDLE all sdr_* outputs are 0.
//  - Return path: x_ack_o = (state==GNT_x) & (sdr_ack_i | timeout).
//    - x_dat_o = sdr_dat_i when granted, else 32'h0.
//    - The ungranted master never sees an ack.
//  - Timeout counter:
//    - Cleared in IDLE; increments each GRANT cycle without ack.
//    - At count == TIMEOUT_CYC: force a one-cycle ack to the granted master with x_dat_o = 32'hFFFF_FFFF, set arb_timeout_o, return to IDLE.
//  - Simultaneous events: if sdr_ack_i and timeout occur in the same cycle, sdr_ack_i wins (real data returned, flag not set).
//  - Abort: granted master drops cyc mid-transfer -> IDLE next cycle, no ack, counter cleared. A late sdr_ack_i that arrives in IDLE is ignored.
//  - Reset (any cycle, mid-transfer included): state=IDLE, last_gnt=CPU, counter=0, arb_timeout_o=0. All outputs are 0 while wb_rst_ni is low.
// STRUCTURE
//  - Shared package/include: FSM state encodings (ARB_IDLE=2'd0, ARB_GNT_CPU=2'd1, ARB_GNT_DMA=2'd2) and TIMEOUT_DATA=32'hFFFF_FFFF.
//  - One natural sub-module: arb_timeout_cnt (clear, enable, terminal-count compare).
//  - Grant FSM and muxes stay flat in the top module.
// TESTING
//  1. CPU-only read at 0x3800_0010, slave acks after 3 cycles with 0x1234_5678 -> cpu_ack_o one cycle, cpu_dat_o=0x1234_5678, dma_ack_o stays 0.
//  2. Both request in the same cycle after reset, DMA_PRIO=0 -> DMA granted first. Next tie -> CPU granted, alternating thereafter.
//  3. DMA_PRIO=1, CPU and DMA both request continuously for 10 transfers -> all DMA granted, CPU starves (expected).
//  4. Slave never acks, TIMEOUT_CYC=255 -> granted master gets ack with 0xFFFF_FFFF 256 cycles after grant; arb_timeout_o=1 and stays 1.
//  5. DMA write granted, dma_cyc_i dropped 2 cycles later -> sdr_stb_o low the same cycle, IDLE next cycle, a pending CPU request is granted the cycle after.
//  6. wb_rst_ni pulsed low mid-GNT_CPU -> all sdr_*, ack and flag outputs 0. After release, a tie goes to the DMA.

Source files
------------

// File: rtl/sdram_wb_arbiter_pkg.sv
// Shared types and constants for the two-master SDRAM Wishbone arbiter.
package sdram_wb_arbiter_pkg;

  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_AW = 32;
  localparam int unsigned WB_SW = 4;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GNT_CPU = 2'd1,
    ARB_GNT_DMA = 2'd2
  } arb_state_e;

  localparam logic [WB_DW-1:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

  // Master-side request payload forwarded to the slave when granted
  typedef struct packed {
    logic             we;
    logic [WB_SW-1:0] sel;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/sdram_wb_arbiter_timeout_cnt.sv
// Grant-phase watchdog: counts un-acked grant cycles, flags terminal count.
module sdram_wb_arbiter_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_WIDTH    = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [TO_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + TO_WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == TO_WIDTH'(TIMEOUT_CYC));

endmodule

// File: rtl/sdram_wb_arbiter.sv
// Two-master (CPU, DMA) to one-slave Wishbone arbiter in front of the SDRAM controller.
module sdram_wb_arbiter
  import sdram_wb_arbiter_pkg::*;
#(
  parameter int unsigned DMA_PRIO    = 0,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_WIDTH    = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             cpu_stb_i,
  input  logic             cpu_cyc_i,
  input  logic             cpu_we_i,
  input  logic [WB_SW-1:0] cpu_sel_i,
  input  logic [WB_AW-1:0] cpu_adr_i,
  input  logic [WB_DW-1:0] cpu_dat_i,
  output logic             cpu_ack_o,
  output logic [WB_DW-1:0] cpu_dat_o,
  input  logic             dma_stb_i,
  input  logic             dma_cyc_i,
  input  logic             dma_we_i,
  input  logic [WB_SW-1:0] dma_sel_i,
  input  logic [WB_AW-1:0] dma_adr_i,
  input  logic [WB_DW-1:0] dma_dat_i,
  output logic             dma_ack_o,
  output logic [WB_DW-1:0] dma_dat_o,
  output logic             sdr_stb_o,
  output logic             sdr_cyc_o,
  output logic             sdr_we_o,
  output logic [WB_SW-1:0] sdr_sel_o,
  output logic [WB_AW-1:0] sdr_adr_o,
  output logic [WB_DW-1:0] sdr_dat_o,
  input  logic             sdr_ack_i,
  input  logic [WB_DW-1:0] sdr_dat_i,
  output logic             arb_busy_o,
  output logic             arb_timeout_o
);

  arb_state_e state_q, state_d;
  logic       last_gnt_q, last_gnt_d;   // 1 = DMA held the last grant
  logic       timeout_q, timeout_d;

  logic       req_cpu, req_dma;
  logic       granted, tc, to_hit;
  wb_req_t    cpu_req, dma_req, gnt_req;
  logic [WB_DW-1:0] ret_dat;

  assign req_cpu = cpu_cyc_i & cpu_stb_i;
  assign req_dma = dma_cyc_i & dma_stb_i;
  assign cpu_req = '{we: cpu_we_i, sel: cpu_sel_i, adr: cpu_adr_i, dat: cpu_dat_i};
  assign dma_req = '{we: dma_we_i, sel: dma_sel_i, adr: dma_adr_i, dat: dma_dat_i};

  assign granted = (state_q != ARB_IDLE);
  // A real ack in the terminal-count cycle takes precedence over the timeout
  assign to_hit  = granted & tc & ~sdr_ack_i;
  assign ret_dat = to_hit ? TIMEOUT_DATA : sdr_dat_i;

  sdram_wb_arbiter_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_WIDTH    (TO_WIDTH)
  ) u_timeout_cnt (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_ni),
    .clr_i  (~granted),
    .en_i   (granted & ~sdr_ack_i),
    .tc_o   (tc)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q    <= ARB_IDLE;
      last_gnt_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state: arbitration in IDLE, completion/abort/timeout in grant states
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    timeout_d  = timeout_q | to_hit;
    unique case (state_q)
      ARB_IDLE: begin
        if (req_dma && (!req_cpu || (DMA_PRIO != 0) || !last_gnt_q)) begin
          state_d    = ARB_GNT_DMA;
          last_gnt_d = 1'b1;
        end else if (req_cpu) begin
          state_d    = ARB_GNT_CPU;
          last_gnt_d = 1'b0;
        end
      end
      ARB_GNT_CPU: if (!req_cpu || sdr_ack_i || tc) state_d = ARB_IDLE;
      ARB_GNT_DMA: if (!req_dma || sdr_ack_i || tc) state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  // Outputs: slave mux and return path, all forced low while in reset
  always_comb begin
    gnt_req       = '0;
    sdr_stb_o     = 1'b0;
    sdr_cyc_o     = 1'b0;
    cpu_ack_o     = 1'b0;
    cpu_dat_o     = '0;
    dma_ack_o     = 1'b0;
    dma_dat_o     = '0;
    arb_busy_o    = 1'b0;
    arb_timeout_o = 1'b0;
    if (wb_rst_ni) begin
      arb_timeout_o = timeout_q;
      unique case (state_q)
        ARB_GNT_CPU: begin
          gnt_req    = cpu_req;
          sdr_stb_o  = req_cpu;
          sdr_cyc_o  = req_cpu;
          cpu_ack_o  = sdr_ack_i | tc;
          cpu_dat_o  = ret_dat;
          arb_busy_o = 1'b1;
        end
        ARB_GNT_DMA: begin
          gnt_req    = dma_req;
          sdr_stb_o  = req_dma;
          sdr_cyc_o  = req_dma;
          dma_ack_o  = sdr_ack_i | tc;
          dma_dat_o  = ret_dat;
          arb_busy_o = 1'b1;
        end
        default: ;
      endcase
    end
    sdr_we_o  = gnt_req.we;
    sdr_sel_o = gnt_req.sel;
    sdr_adr_o = gnt_req.adr;
    sdr_dat_o = gnt_req.dat;
  end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Directed bench: round-robin and DMA-priority arbiters driven by one shared stimulus.
module tb_sdram_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_stb, cpu_cyc, cpu_we;
  logic [3:0]  cpu_sel;
  logic [31:0] cpu_adr, cpu_dat;
  logic        dma_stb, dma_cyc, dma_we;
  logic [3:0]  dma_sel;
  logic [31:0] dma_adr, dma_dat;
  logic        sdr_ack;
  logic [31:0] sdr_rdat;

  logic        cpu_ack_rr, dma_ack_rr, stb_rr, cyc_rr, we_rr, busy_rr, to_rr;
  logic [31:0] cpu_dat_rr, dma_dat_rr, adr_rr, wdat_rr;
  logic [3:0]  sel_rr;
  logic        cpu_ack_fp, dma_ack_fp, stb_fp, cyc_fp, we_fp, busy_fp, to_fp;
  logic [31:0] cpu_dat_fp, dma_dat_fp, adr_fp, wdat_fp;
  logic [3:0]  sel_fp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdram_wb_arbiter #(.DMA_PRIO(0), .TIMEOUT_CYC(255), .TO_WIDTH(8)) u_dut_rr (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cpu_stb_i(cpu_stb), .cpu_cyc_i(cpu_cyc), .cpu_we_i(cpu_we), .cpu_sel_i(cpu_sel),
    .cpu_adr_i(cpu_adr), .cpu_dat_i(cpu_dat), .cpu_ack_o(cpu_ack_rr), .cpu_dat_o(cpu_dat_rr),
    .dma_stb_i(dma_stb), .dma_cyc_i(dma_cyc), .dma_we_i(dma_we), .dma_sel_i(dma_sel),
    .dma_adr_i(dma_adr), .dma_dat_i(dma_dat), .dma_ack_o(dma_ack_rr), .dma_dat_o(dma_dat_rr),
    .sdr_stb_o(stb_rr), .sdr_cyc_o(cyc_rr), .sdr_we_o(we_rr), .sdr_sel_o(sel_rr),
    .sdr_adr_o(adr_rr), .sdr_dat_o(wdat_rr), .sdr_ack_i(sdr_ack), .sdr_dat_i(sdr_rdat),
    .arb_busy_o(busy_rr), .arb_timeout_o(to_rr)
  );

  sdram_wb_arbiter #(.DMA_PRIO(1), .TIMEOUT_CYC(255), .TO_WIDTH(8)) u_dut_fp (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cpu_stb_i(cpu_stb), .cpu_cyc_i(cpu_cyc), .cpu_we_i(cpu_we), .cpu_sel_i(cpu_sel),
    .cpu_adr_i(cpu_adr), .cpu_dat_i(cpu_dat), .cpu_ack_o(cpu_ack_fp), .cpu_dat_o(cpu_dat_fp),
    .dma_stb_i(dma_stb), .dma_cyc_i(dma_cyc), .dma_we_i(dma_we), .dma_sel_i(dma_sel),
    .dma_adr_i(dma_adr), .dma_dat_i(dma_dat), .dma_ack_o(dma_ack_fp), .dma_dat_o(dma_dat_fp),
    .sdr_stb_o(stb_fp), .sdr_cyc_o(cyc_fp), .sdr_we_o(we_fp), .sdr_sel_o(sel_fp),
    .sdr_adr_o(adr_fp), .sdr_dat_o(wdat_fp), .sdr_ack_i(sdr_ack), .sdr_dat_i(sdr_rdat),
    .arb_busy_o(busy_fp), .arb_timeout_o(to_fp)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    cpu_stb = 0; cpu_cyc = 0; cpu_we = 0; cpu_sel = 4'h0; cpu_adr = '0; cpu_dat = '0;
    dma_stb = 0; dma_cyc = 0; dma_we = 0; dma_sel = 4'h0; dma_adr = '0; dma_dat = '0;
    sdr_ack = 0; sdr_rdat = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    drive_idle();
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [31:0] adr);
    cpu_cyc = req; cpu_stb = req; cpu_we = we; cpu_sel = 4'hF; cpu_adr = adr; cpu_dat = 32'hC0C0_0000;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    dma_cyc = req; dma_stb = req; dma_we = we; dma_sel = 4'h3; dma_adr = adr; dma_dat = dat;
  endtask

  // Called in an IDLE cycle with requests driven; runs one 0-wait transfer
  task automatic xfer(input string tag, input bit fp, input bit exp_dma);
    logic [31:0] adr_a;
    logic        ca, da, busy;
    tick();
    sdr_ack = 1; sdr_rdat = 32'h0BAD_F00D;
    #1;
    adr_a = fp ? adr_fp : adr_rr;
    ca    = fp ? cpu_ack_fp : cpu_ack_rr;
    da    = fp ? dma_ack_fp : dma_ack_rr;
    check_eq({tag, "_adr"}, adr_a, exp_dma ? dma_adr : cpu_adr);
    check_eq({tag, "_dma_ack"}, 32'(da), 32'(exp_dma));
    check_eq({tag, "_cpu_ack"}, 32'(ca), 32'(!exp_dma));
    tick();
    sdr_ack = 0;
    #1;
    busy = fp ? busy_fp : busy_rr;
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic timeout_run(input bit ack_at_tc);
    do_reset();
    set_dma(1, 0, 32'h3800_0100, 32'h0);
    sdr_rdat = 32'h5A5A_0001;
    #1;
    tick();
    for (int i = 1; i < 255; i++) tick();
    check_eq("to_early_ack", 32'(dma_ack_rr), 32'd0);
    tick();
    sdr_ack = ack_at_tc;
    #1;
    check_eq("to_ack", 32'(dma_ack_rr), 32'd1);
    check_eq("to_dat", dma_dat_rr, ack_at_tc ? 32'h5A5A_0001 : 32'hFFFF_FFFF);
    check_eq("to_cpu_ack", 32'(cpu_ack_rr), 32'd0);
    check_eq("to_flag_pre", 32'(to_rr), 32'd0);
    tick();
    set_dma(0, 0, 32'h0, 32'h0);
    sdr_ack = 0;
    #1;
    check_eq("to_flag", 32'(to_rr), 32'(!ack_at_tc));
    check_eq("to_busy", 32'(busy_rr), 32'd0);
    tick(); tick();
    check_eq("to_flag_sticky", 32'(to_rr), 32'(!ack_at_tc));
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    do_reset();
    #1;
    check_eq("rst_busy", 32'(busy_rr), 32'd0);
    check_eq("rst_flag", 32'(to_rr), 32'd0);
    check_eq("rst_stb", 32'(stb_rr), 32'd0);

    // CPU-only read, slave acks on the third grant cycle
    set_cpu(1, 0, 32'h3800_0010);
    #1;
    check_eq("t1_stb_idle", 32'(stb_rr), 32'd0);
    tick();
    check_eq("t1_stb", 32'(stb_rr), 32'd1);
    check_eq("t1_adr", adr_rr, 32'h3800_0010);
    check_eq("t1_ack_w1", 32'(cpu_ack_rr), 32'd0);
    tick();
    check_eq("t1_ack_w2", 32'(cpu_ack_rr), 32'd0);
    tick();
    sdr_ack = 1; sdr_rdat = 32'h1234_5678;
    #1;
    check_eq("t1_ack", 32'(cpu_ack_rr), 32'd1);
    check_eq("t1_dat", cpu_dat_rr, 32'h1234_5678);
    check_eq("t1_dma_ack", 32'(dma_ack_rr), 32'd0);
    check_eq("t1_dma_dat", dma_dat_rr, 32'h0);
    tick();
    set_cpu(0, 0, 32'h0);
    sdr_ack = 0;
    #1;
    check_eq("t1_ack_off", 32'(cpu_ack_rr), 32'd0);
    check_eq("t1_busy_off", 32'(busy_rr), 32'd0);

    // Round-robin ties alternate starting with the DMA
    do_reset();
    set_cpu(1, 0, 32'h3800_0020);
    set_dma(1, 0, 32'h3900_0040, 32'h0);
    #1;
    for (int i = 0; i < 4; i++) xfer("t2_rr", 1'b0, (i % 2) == 0);

    // Fixed priority: DMA wins every tie
    for (int i = 0; i < 10; i++) xfer("t3_fp", 1'b1, 1'b1);
    set_cpu(0, 0, 32'h0);
    set_dma(0, 0, 32'h0, 32'h0);

    timeout_run(1'b0);

    // Reset mid-grant with the sticky flag already set
    set_cpu(1, 0, 32'h3800_0030);
    #1;
    tick();
    check_eq("t6_busy_pre", 32'(busy_rr), 32'd1);
    check_eq("t6_flag_pre", 32'(to_rr), 32'd1);
    rst_n = 0; sdr_ack = 1; sdr_rdat = 32'hDEAD_BEEF;
    #1;
    check_eq("t6_stb", 32'(stb_rr), 32'd0);
    check_eq("t6_cyc", 32'(cyc_rr), 32'd0);
    check_eq("t6_adr", adr_rr, 32'h0);
    check_eq("t6_ack", 32'(cpu_ack_rr), 32'd0);
    check_eq("t6_dat", cpu_dat_rr, 32'h0);
    check_eq("t6_busy", 32'(busy_rr), 32'd0);
    check_eq("t6_flag", 32'(to_rr), 32'd0);
    tick();
    rst_n = 1; sdr_ack = 0;
    set_dma(1, 0, 32'h3900_0080, 32'h0);
    #1;
    check_eq("t6_idle", 32'(busy_rr), 32'd0);
    check_eq("t6_flag_post", 32'(to_rr), 32'd0);
    xfer("t6_tie", 1'b0, 1'b1);

    // DMA write aborted mid-transfer; pending CPU request follows
    do_reset();
    set_cpu(1, 0, 32'h3800_0050);
    set_dma(1, 1, 32'h3900_00C0, 32'hAAAA_5555);
    #1;
    tick();
    check_eq("t5_adr", adr_rr, 32'h3900_00C0);
    check_eq("t5_we", 32'(we_rr), 32'd1);
    check_eq("t5_wdat", wdat_rr, 32'hAAAA_5555);
    check_eq("t5_sel", 32'(sel_rr), 32'h3);
    tick();
    tick();
    dma_cyc = 0;
    #1;
    check_eq("t5_stb_abort", 32'(stb_rr), 32'd0);
    check_eq("t5_cyc_abort", 32'(cyc_rr), 32'd0);
    check_eq("t5_dma_ack", 32'(dma_ack_rr), 32'd0);
    tick();
    sdr_ack = 1;
    #1;
    check_eq("t5_idle", 32'(busy_rr), 32'd0);
    check_eq("t5_late_dma", 32'(dma_ack_rr), 32'd0);
    check_eq("t5_late_cpu", 32'(cpu_ack_rr), 32'd0);
    tick();
    sdr_ack = 0;
    #1;
    check_eq("t5_cpu_gnt", 32'(busy_rr), 32'd1);
    check_eq("t5_cpu_adr", adr_rr, 32'h3800_0050);
    check_eq("t5_cpu_we", 32'(we_rr), 32'd0);
    set_cpu(0, 0, 32'h0);

    // Real ack coincident with terminal count beats the timeout
    timeout_run(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
